// File: rtl/spm_pkg.sv
// Shared scratchpad constants, also used by the core for SPM window decode.
package spm_pkg;

    localparam int unsigned SPM_ADDR_WIDTH = 10;
    localparam int unsigned SPM_DATA_WIDTH = 32;
    localparam int unsigned SPM_BYTES      = SPM_DATA_WIDTH / 8;

endpackage : spm_pkg

// File: rtl/spm_byte_lane.sv
// One 8-bit byte lane of the scratchpad: synchronous write, combinational read
// of the stored word (the top level registers it).
module spm_byte_lane
    import spm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SPM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [7:0]            rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    // Lane storage write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Pre-write array contents; gives read-before-write on a same-address hit.
    assign rdata_c = mem[raddr];

endmodule : spm_byte_lane

// File: rtl/spm_sram.sv
// Scratchpad memory: DEPTH words x DATA_WIDTH, one read port, one byte-masked
// write port, one-cycle registered read latency.
// Optional feature macro: SPM_RDW_FORWARD_EN (same-address read returns the
// newly written bytes merged with the old word).
module spm_sram
    import spm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SPM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SPM_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   spm_rdaddress,
    input  logic                    spm_rden,
    input  logic [ADDR_WIDTH-1:0]   spm_wraddress,
    input  logic                    spm_wren,
    input  logic [DATA_WIDTH-1:0]   spm_write_data,
    input  logic [DATA_WIDTH/8-1:0] spm_store_byteena,
    output logic [DATA_WIDTH-1:0]   spm_rd_data
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [BYTES-1:0]      lane_we_c;
    logic [DATA_WIDTH-1:0] old_word_c;
    logic [DATA_WIDTH-1:0] rd_next_c;

    // Per-lane write enable; writes are suppressed while in reset.
    assign lane_we_c = {BYTES{rst_n & spm_wren}} & spm_store_byteena;

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        spm_byte_lane #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk     (clk),
            .we      (lane_we_c[k]),
            .waddr   (spm_wraddress),
            .wdata   (spm_write_data[8*k +: 8]),
            .raddr   (spm_rdaddress),
            .rdata_c (old_word_c[8*k +: 8])
        );
    end

    // Read data select: old array word, or per-lane bypass of the write data.
    always_comb begin
        rd_next_c = old_word_c;
`ifdef SPM_RDW_FORWARD_EN
        if (spm_wren && (spm_wraddress == spm_rdaddress)) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (spm_store_byteena[k]) begin
                    rd_next_c[8*k +: 8] = spm_write_data[8*k +: 8];
                end
            end
        end
`endif
    end

    // Registered read port with synchronous clear; holds when not reading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spm_rd_data <= '0;
        end else if (spm_rden) begin
            spm_rd_data <= rd_next_c;
        end
    end

endmodule : spm_sram

// File: tb/tb_spm_sram.sv
// Directed, table-driven bench for spm_sram.
module tb_spm_sram;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned NV = 18;

`ifdef SPM_RDW_FORWARD_EN
    localparam logic [31:0] RDW_EXP = 32'hCAFE0000;
`else
    localparam logic [31:0] RDW_EXP = 32'h00000000;
`endif

    // mode: 0 = no check, 1 = must equal exp, 2 = must differ from exp
    typedef struct {
        logic        rst_n;
        logic        wren;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rden;
        logic [9:0]  raddr;
        int          mode;
        logic [31:0] exp;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] spm_rdaddress;
    logic          spm_rden;
    logic [AW-1:0] spm_wraddress;
    logic          spm_wren;
    logic [DW-1:0] spm_write_data;
    logic [3:0]    spm_store_byteena;
    logic [DW-1:0] spm_rd_data;

    int total;
    int bad;
    vec_t vecs [NV];

    spm_sram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .spm_rdaddress     (spm_rdaddress),
        .spm_rden          (spm_rden),
        .spm_wraddress     (spm_wraddress),
        .spm_wren          (spm_wren),
        .spm_write_data    (spm_write_data),
        .spm_store_byteena (spm_store_byteena),
        .spm_rd_data       (spm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic we, input logic [9:0] wa,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic re, input logic [9:0] ra,
                                input int mode, input logic [31:0] exp);
        vec_t v;
        v.rst_n = r;  v.wren = we; v.waddr = wa; v.wdata = wd; v.be = be;
        v.rden = re;  v.raddr = ra; v.mode = mode; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst_n             = v.rst_n;
        spm_wren          = v.wren;
        spm_wraddress     = v.waddr;
        spm_write_data    = v.wdata;
        spm_store_byteena = v.be;
        spm_rden          = v.rden;
        spm_rdaddress     = v.raddr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int mode, input logic [31:0] exp);
        total++;
        if (mode == 2) begin
            if (spm_rd_data === exp) begin
                bad++;
                $display("FAIL %s: got %h, required anything but %h", name, spm_rd_data, exp);
            end
        end else if (spm_rd_data !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, spm_rd_data, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; spm_wren = 1'b0; spm_wraddress = '0; spm_write_data = '0;
        spm_store_byteena = '0; spm_rden = 1'b0; spm_rdaddress = '0;

        vecs[0]  = mk(0, 0, 10'h000, 32'h0,        4'h0, 1, 10'h000, 1, 32'h00000000); // reset
        vecs[1]  = mk(0, 1, 10'h005, 32'h11223344, 4'hF, 1, 10'h005, 1, 32'h00000000); // write in reset
        vecs[2]  = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h005, 2, 32'h11223344); // suppressed
        vecs[3]  = mk(1, 1, 10'h3FF, 32'hDEADBEEF, 4'hF, 0, 10'h000, 0, 32'h0);
        vecs[4]  = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h3FF, 1, 32'hDEADBEEF); // top addr
        vecs[5]  = mk(1, 1, 10'h007, 32'hAABBCCDD, 4'hF, 0, 10'h000, 1, 32'hDEADBEEF);
        vecs[6]  = mk(1, 1, 10'h007, 32'h11223344, 4'h5, 0, 10'h000, 1, 32'hDEADBEEF);
        vecs[7]  = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h007, 1, 32'hAA22CC44); // mask
        vecs[8]  = mk(1, 1, 10'h007, 32'hFFFFFFFF, 4'h0, 1, 10'h007, 1, 32'hAA22CC44); // be=0
        vecs[9]  = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h007, 1, 32'hAA22CC44);
        vecs[10] = mk(1, 1, 10'h007, 32'h01020304, 4'hF, 0, 10'h007, 1, 32'hAA22CC44); // hold
        vecs[11] = mk(1, 0, 10'h000, 32'h0,        4'h0, 0, 10'h007, 1, 32'hAA22CC44);
        vecs[12] = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h007, 1, 32'h01020304);
        vecs[13] = mk(1, 1, 10'h009, 32'h00000000, 4'hF, 0, 10'h000, 1, 32'h01020304);
        vecs[14] = mk(1, 1, 10'h009, 32'hCAFEF00D, 4'hC, 1, 10'h009, 1, RDW_EXP);      // RDW
        vecs[15] = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h009, 1, 32'hCAFE0000);
        vecs[16] = mk(1, 1, 10'h100, 32'h89ABCDEF, 4'hF, 1, 10'h3FF, 1, 32'hDEADBEEF); // diff addr
        vecs[17] = mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h100, 1, 32'h89ABCDEF);

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i]);
            if (vecs[i].mode != 0) begin
                check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].exp);
            end
        end

        // Reset pulse mid-stream: output clears, array survives, write in reset dropped.
        drive(mk(1, 1, 10'h003, 32'h12345678, 4'hF, 1, 10'h3FF, 0, 32'h0));
        check("pre_reset_read", 1, 32'hDEADBEEF);
        drive(mk(0, 1, 10'h003, 32'h00000000, 4'hF, 1, 10'h003, 0, 32'h0));
        check("reset_pulse_out", 1, 32'h00000000);
        drive(mk(1, 0, 10'h000, 32'h0,        4'h0, 1, 10'h003, 0, 32'h0));
        check("post_reset_read", 1, 32'h12345678);
        drive(mk(1, 0, 10'h000, 32'h0,        4'h0, 0, 10'h000, 0, 32'h0));
        check("post_reset_hold", 1, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spm_sram

// File: doc/spm_sram.md
# spm_sram

Single-port-pair scratchpad memory (SPM) for the out-of-order core's load/store unit. It provides 1024 words of 32 bits, with one synchronous read port and one synchronous write port that has per-byte write enables. Loads and stores that hit the SPM address window bypass the AHB bus and are served here with fixed one-cycle read latency.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-index width; DEPTH = 2**ADDR_WIDTH = 1024 words.
- DATA_WIDTH, 32: word width; must be a multiple of 8; byte lanes = DATA_WIDTH/8 = 4.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- spm_rdaddress  in  ADDR_WIDTH  read word index.
- spm_rden  in  1  read enable.
- spm_wraddress  in  ADDR_WIDTH  write word index.
- spm_wren  in  1  write enable.
- spm_write_data  in  DATA_WIDTH  store data, lane-aligned.
- spm_store_byteena  in  DATA_WIDTH/8  byte write mask; bit k covers bits [8k+7:8k].
- spm_rd_data  out  DATA_WIDTH  registered read data.

## Operation
- Addresses are word indices, not byte addresses. The core drives address bits [9:0] of its word index; no address bits are dropped inside the block.
- Write: on a rising clk with rst_n=1 and spm_wren=1, each lane k whose spm_store_byteena[k]=1 takes the corresponding byte of spm_write_data. Lanes with a 0 enable keep their old value. If spm_wren=1 and spm_store_byteena=0, the write is a no-op.
- Read: on a rising clk with rst_n=1 and spm_rden=1, spm_rd_data <= mem[spm_rdaddress]. With spm_rden=0, spm_rd_data holds its previous value.
- Reset: while rst_n=0 at a clock edge, spm_rd_data <= 0 and all writes are suppressed. Array contents are not cleared by reset and survive a reset pulse unchanged.
- Simultaneous read and write to different addresses are independent.
- Read and write to the same address in the same cycle: the result is set by the read-during-write macro (see Configuration).
- Out-of-range addresses are impossible, because DEPTH = 2**ADDR_WIDTH.
- Power-up array content is X and is not specified; software must initialise before reading.

## Timing
- Read latency is 1 cycle: the address and rden sampled at edge N produce data visible on spm_rd_data after edge N.
- Write latency is 1 cycle: a word written at edge N is readable by a read sampled at edge N+1, returning data after edge N+1.
- There is no handshake and no stall; the block accepts one read and one write every cycle.
- spm_rd_data reset value is 0.

## Configuration
- Macro SPM_RDW_FORWARD_EN.
- Defined: a same-address read and write in one cycle returns the new data, merged per lane. Lanes with byteena=1 come from spm_write_data; other lanes come from the old array word. This is implemented as an explicit bypass mux on the registered output.
- Undefined: a same-address read and write returns the old array word (read-before-write). The write still commits.

## Structure
- Shared package spm_pkg holds SPM_ADDR_WIDTH (10), SPM_DATA_WIDTH (32) and SPM_BYTES (4). The core uses the same constants for the SPM window decode.
- One natural sub-module is spm_byte_lane: an 8-bit-wide, DEPTH-deep RAM with its own write enable (spm_wren & spm_store_byteena[k]). It is instantiated DATA_WIDTH/8 times via a generate loop.
- The top level owns the output register, the reset and the forwarding mux.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with spm_rden=1 -> spm_rd_data=0x00000000 throughout; then write 0x11223344 to addr 5 during reset -> a later read of addr 5 does not return 0x11223344.
- Full-word write/read: write 0xDEADBEEF to addr 0x3FF with byteena=4'hF, then rden at addr 0x3FF next cycle -> 0xDEADBEEF one cycle after the read.
- Byte masking: addr 7 holds 0xAABBCCDD; write 0x11223344 with byteena=4'b0101 -> read returns 0xAA22CC44. Byteena=0 with wren=1 -> the word is unchanged.
- Read hold: read addr 7, then deassert rden and write addr 7 -> spm_rd_data keeps its last value until the next rden.
- Read-during-write at addr 9 (old value 0x00000000; write 0xCAFEF00D with byteena=4'b1100; rden same cycle) -> returns 0xCAFE0000 with SPM_RDW_FORWARD_EN, 0x00000000 without. The next read returns 0xCAFE0000 in both builds.
- Reset mid-stream: write addr 3 = 0x12345678, pulse rst_n low for 1 cycle, read addr 3 -> 0x12345678, with spm_rd_data=0 during the reset cycle.
